// File: rtl/square_animator.sv
// -----------------------------------------------------------------------------
// square_animator
//
// Pixel-generation stage fed by the 800x600 VGA timing driver. It moves one
// solid square across the screen. The square bounces off the screen edges and
// changes colour on every frame that contains a bounce.
//
// Ports
//   i_clk         base clock
//   i_rst         synchronous, active-high reset (priority over all inputs)
//   i_pix_stb     pixel strobe, one i_clk cycle wide
//   i_x, i_y      current pixel position from the timing driver
//   i_active      high during active drawing
//   i_animate     end-of-active-frame tick, held for one full pixel period
//   i_freeze      request to pause motion (sampled only on the frame tick)
//   o_r/o_g/o_b   registered 4-bit colour channels, one strobe of latency
//   o_bounce_cnt  saturating count of frames that contained a bounce
//   o_frozen      high while motion is paused
//
// Optional build macro
//   SQUARE_BORDER_EN : draws a white 1-pixel border on the outermost active
//                      rows/columns, on top of the square.
// -----------------------------------------------------------------------------
module square_animator #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int SIZE  = 40,
  parameter int IX    = 400,
  parameter int IY    = 300,
  parameter int H_DIR = 1,
  parameter int V_DIR = 1,
  parameter int SPEED = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic [10:0] i_x,
  input  logic [9:0]  i_y,
  input  logic        i_active,
  input  logic        i_animate,
  input  logic        i_freeze,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic [7:0]  o_bounce_cnt,
  output logic        o_frozen
);

  // Axis limits. The "threshold" values are the last position from which a
  // full SPEED step would reach or pass the edge, so the bounce clamps there.
  localparam logic [10:0] X_HALF  = 11'(SIZE);
  localparam logic [10:0] X_STEP  = 11'(SPEED);
  localparam logic [10:0] X_MIN   = 11'(SIZE);
  localparam logic [10:0] X_MAX   = 11'(H_RES - SIZE);
  localparam logic [10:0] X_LO_TH = 11'(SIZE + SPEED);
  localparam logic [10:0] X_HI_TH = 11'(H_RES - SIZE - SPEED);
  localparam logic [10:0] X_INIT  = 11'(IX);

  localparam logic [9:0]  Y_HALF  = 10'(SIZE);
  localparam logic [9:0]  Y_STEP  = 10'(SPEED);
  localparam logic [9:0]  Y_MIN   = 10'(SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(V_RES - SIZE);
  localparam logic [9:0]  Y_LO_TH = 10'(SIZE + SPEED);
  localparam logic [9:0]  Y_HI_TH = 10'(V_RES - SIZE - SPEED);
  localparam logic [9:0]  Y_INIT  = 10'(IY);

`ifdef SQUARE_BORDER_EN
  localparam logic [10:0] X_LAST  = 11'(H_RES - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_RES - 1);
`endif

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Palette lookup: index 3 is unreachable and maps to black.
  function automatic logic [11:0] palette_rgb(input logic [1:0] idx);
    logic [11:0] rgb;
    case (idx)
      2'd0:    rgb = 12'hF00;
      2'd1:    rgb = 12'h0F0;
      2'd2:    rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  state_t      state_r, state_n_s;
  logic [10:0] cx_r, cx_n_s;
  logic [9:0]  cy_r, cy_n_s;
  logic        dx_r, dx_n_s;
  logic        dy_r, dy_n_s;
  logic [1:0]  pal_r, pal_n_s;
  logic [7:0]  cnt_r, cnt_n_s;
  logic        frozen_r;
  logic [11:0] rgb_r, rgb_n_s;

  logic        tick_s;
  logic        move_s;
  logic        x_bounce_s;
  logic        y_bounce_s;
  logic        in_sq_s;

  assign tick_s = i_pix_stb & i_animate;

  // Pause/run control: the state only changes on a frame tick, and the tick
  // that changes state never moves the square.
  always_comb begin
    state_n_s = state_r;
    move_s    = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_RUN: begin
          if (i_freeze) begin
            state_n_s = ST_HOLD;
          end else begin
            move_s = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!i_freeze) begin
            state_n_s = ST_RUN;
          end else begin
            state_n_s = ST_HOLD;
          end
        end
        default: state_n_s = ST_RUN;
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Per-axis motion with edge clamping and direction reversal.
  always_comb begin
    cx_n_s     = cx_r;
    cy_n_s     = cy_r;
    dx_n_s     = dx_r;
    dy_n_s     = dy_r;
    x_bounce_s = 1'b0;
    y_bounce_s = 1'b0;
    if (move_s) begin
      if (dx_r) begin
        if (cx_r >= X_HI_TH) begin
          cx_n_s     = X_MAX;
          dx_n_s     = 1'b0;
          x_bounce_s = 1'b1;
        end else begin
          cx_n_s = cx_r + X_STEP;
        end
      end else begin
        if (cx_r <= X_LO_TH) begin
          cx_n_s     = X_MIN;
          dx_n_s     = 1'b1;
          x_bounce_s = 1'b1;
        end else begin
          cx_n_s = cx_r - X_STEP;
        end
      end
      if (dy_r) begin
        if (cy_r >= Y_HI_TH) begin
          cy_n_s     = Y_MAX;
          dy_n_s     = 1'b0;
          y_bounce_s = 1'b1;
        end else begin
          cy_n_s = cy_r + Y_STEP;
        end
      end else begin
        if (cy_r <= Y_LO_TH) begin
          cy_n_s     = Y_MIN;
          dy_n_s     = 1'b1;
          y_bounce_s = 1'b1;
        end else begin
          cy_n_s = cy_r - Y_STEP;
        end
      end
    end else begin
      cx_n_s = cx_r;
      cy_n_s = cy_r;
    end
  end

  // Colour and bounce counter advance once per frame with any bounce, even
  // when both axes bounce together.
  always_comb begin
    pal_n_s = pal_r;
    cnt_n_s = cnt_r;
    if (x_bounce_s | y_bounce_s) begin
      if (pal_r == 2'd2) begin
        pal_n_s = 2'd0;
      end else begin
        pal_n_s = pal_r + 2'd1;
      end
      if (cnt_r == 8'hFF) begin
        cnt_n_s = cnt_r;
      end else begin
        cnt_n_s = cnt_r + 8'd1;
      end
    end else begin
      pal_n_s = pal_r;
    end
  end

  // Square hit test. cx >= SIZE always, so the subtraction cannot wrap.
  assign in_sq_s = (i_x >= (cx_r - X_HALF)) && (i_x < (cx_r + X_HALF)) &&
                   (i_y >= (cy_r - Y_HALF)) && (i_y < (cy_r + Y_HALF));

  // Next pixel colour: black in blanking, square colour on a hit.
  always_comb begin
    rgb_n_s = 12'h000;
    if (i_active) begin
`ifdef SQUARE_BORDER_EN
      if ((i_x == 11'd0) || (i_x == X_LAST) ||
          (i_y == 10'd0) || (i_y == Y_LAST)) begin
        rgb_n_s = 12'hFFF;
      end else if (in_sq_s) begin
        rgb_n_s = palette_rgb(pal_r);
      end else begin
        rgb_n_s = 12'h000;
      end
`else
      if (in_sq_s) begin
        rgb_n_s = palette_rgb(pal_r);
      end else begin
        rgb_n_s = 12'h000;
      end
`endif
    end else begin
      rgb_n_s = 12'h000;
    end
  end

  // Animation state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_RUN;
      cx_r     <= X_INIT;
      cy_r     <= Y_INIT;
      dx_r     <= 1'(H_DIR);
      dy_r     <= 1'(V_DIR);
      pal_r    <= 2'd0;
      cnt_r    <= 8'd0;
      frozen_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cx_r     <= cx_n_s;
      cy_r     <= cy_n_s;
      dx_r     <= dx_n_s;
      dy_r     <= dy_n_s;
      pal_r    <= pal_n_s;
      cnt_r    <= cnt_n_s;
      frozen_r <= (state_n_s == ST_HOLD);
    end
  end

  // Output colour register: loads on each pixel strobe, holds in between.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_r <= 12'h000;
    end else if (i_pix_stb) begin
      rgb_r <= rgb_n_s;
    end else begin
      rgb_r <= rgb_r;
    end
  end

  assign o_r          = rgb_r[11:8];
  assign o_g          = rgb_r[7:4];
  assign o_b          = rgb_r[3:0];
  assign o_bounce_cnt = cnt_r;
  assign o_frozen     = frozen_r;

endmodule

// File: tb/tb_square_animator.sv
// -----------------------------------------------------------------------------
// tb_square_animator
//
// Self-checking bench for square_animator. A behavioural model tracks the
// square centre, direction, colour index, bounce count and pause state with
// plain integer arithmetic; every observed output is compared to it.
// -----------------------------------------------------------------------------
module tb_square_animator;

  localparam int H_RES = 800;
  localparam int V_RES = 600;
  localparam int SIZE  = 40;
  localparam int SPEED = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pix_stb;
  logic [10:0] i_x;
  logic [9:0]  i_y;
  logic        i_active;
  logic        i_animate;
  logic        i_freeze;
  logic [3:0]  o_r, o_g, o_b;
  logic [7:0]  o_bounce_cnt;
  logic        o_frozen;

  square_animator dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pix_stb   (i_pix_stb),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_active    (i_active),
    .i_animate   (i_animate),
    .i_freeze    (i_freeze),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b),
    .o_bounce_cnt(o_bounce_cnt),
    .o_frozen    (o_frozen)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int mcx, mcy, mdx, mdy, mpal, mcnt;
  bit mhold;
  logic [11:0] pal_tab [3] = '{12'hF00, 12'h0F0, 12'h00F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mcx = 400; mcy = 300; mdx = 1; mdy = 1;
    mpal = 0; mcnt = 0; mhold = 1'b0;
  endtask

  // One axis: step by SPEED, and if the step reaches or passes the allowed
  // range edge, sit exactly on the edge and reverse.
  task automatic model_axis(inout int pos, inout int dir, input int res, inout bit b);
    int np;
    np = pos + dir * SPEED;
    if (np >= res - SIZE) begin
      pos = res - SIZE; dir = -1; b = 1'b1;
    end else if (np <= SIZE) begin
      pos = SIZE; dir = 1; b = 1'b1;
    end else begin
      pos = np;
    end
  endtask

  task automatic model_tick(input bit frz);
    bit b;
    b = 1'b0;
    if (mhold) begin
      if (!frz) mhold = 1'b0;
    end else if (frz) begin
      mhold = 1'b1;
    end else begin
      model_axis(mcx, mdx, H_RES, b);
      model_axis(mcy, mdy, V_RES, b);
      if (b) begin
        mpal = (mpal + 1) % 3;
        if (mcnt < 255) mcnt = mcnt + 1;
      end
    end
  endtask

  function automatic logic [11:0] exp_pix(input int x, input int y, input bit act);
    logic [11:0] c;
    c = 12'h000;
    if (act) begin
      if (x >= mcx - SIZE && x < mcx + SIZE && y >= mcy - SIZE && y < mcy + SIZE)
        c = pal_tab[mpal];
`ifdef SQUARE_BORDER_EN
      if (x == 0 || x == H_RES - 1 || y == 0 || y == V_RES - 1)
        c = 12'hFFF;
`endif
    end
    return c;
  endfunction

  // Present one pixel with a strobe, check the colour one strobe later, then
  // change the inputs without a strobe and check the colour is held.
  task automatic pix(input int x, input int y, input bit act, input string tag);
    logic [11:0] e;
    i_x = 11'(x); i_y = 10'(y); i_active = act; i_animate = 1'b0; i_pix_stb = 1'b1;
    @(posedge i_clk); #1;
    i_pix_stb = 1'b0;
    e = exp_pix(x, y, act);
    check(tag, {20'd0, o_r, o_g, o_b}, {20'd0, e});
    i_x = 11'($urandom_range(0, H_RES - 1));
    i_y = 10'($urandom_range(0, V_RES - 1));
    i_active = 1'b1;
    @(posedge i_clk); #1;
    check({tag, "_hold"}, {20'd0, o_r, o_g, o_b}, {20'd0, e});
  endtask

  task automatic tick(input bit frz);
    i_freeze = frz; i_animate = 1'b1; i_active = 1'b0;
    i_x = 11'(H_RES - 1); i_y = 10'(V_RES - 1); i_pix_stb = 1'b1;
    @(posedge i_clk); #1;
    i_pix_stb = 1'b0; i_animate = 1'b0; i_freeze = 1'b0;
    model_tick(frz);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cnt"}, {24'd0, o_bounce_cnt}, 32'(mcnt));
    check({tag, "_frozen"}, {31'd0, o_frozen}, {31'd0, mhold});
  endtask

  // Probe the square's corners and the pixels just outside each edge.
  task automatic check_square(input string tag);
    pix(mcx - SIZE, mcy - SIZE, 1'b1, {tag, "_tl"});
    pix(mcx + SIZE - 1, mcy + SIZE - 1, 1'b1, {tag, "_br"});
    if (mcx - SIZE - 1 >= 0)    pix(mcx - SIZE - 1, mcy, 1'b1, {tag, "_lout"});
    if (mcx + SIZE < H_RES)     pix(mcx + SIZE, mcy, 1'b1, {tag, "_rout"});
    if (mcy - SIZE - 1 >= 0)    pix(mcx, mcy - SIZE - 1, 1'b1, {tag, "_tout"});
    if (mcy + SIZE < V_RES)     pix(mcx, mcy + SIZE, 1'b1, {tag, "_bout"});
    pix(mcx, mcy, 1'b0, {tag, "_blank"});
    pix($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
        1'($urandom_range(0, 1)), {tag, "_rnd"});
  endtask

  initial begin
    #5_000_000;
    $error("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_pix_stb = 1'b0; i_x = 11'd0; i_y = 10'd0;
    i_active = 1'b0; i_animate = 1'b0; i_freeze = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rgb", {20'd0, o_r, o_g, o_b}, 32'd0);
    check_status("rst");
    i_rst = 1'b0;

    // Reset position: fixed probe pixels and blanking
    pix(360, 260, 1'b1, "p360_260");
    pix(439, 339, 1'b1, "p439_339");
    pix(359, 300, 1'b1, "p359_300");
    pix(440, 300, 1'b1, "p440_300");
    pix(400, 259, 1'b1, "p400_259");
    pix(400, 300, 1'b0, "p_blank");
    pix(0, 0, 1'b1, "edge_0_0");
    pix(799, 300, 1'b1, "edge_799_300");
    pix(400, 599, 1'b1, "edge_400_599");

    // One motion tick
    tick(1'b0);
    check_status("tick1");
    pix(361, 300, 1'b1, "t1_p361");
    pix(362, 300, 1'b1, "t1_p362");
    pix(441, 300, 1'b1, "t1_p441");
    pix(442, 300, 1'b1, "t1_p442");

    // Up to the first (y) bounce, then the first x bounce
    repeat (129) tick(1'b0);
    check_status("tick130");
    check_square("tick130");
    repeat (50) tick(1'b0);
    check_status("tick180");
    check_square("tick180");

    // Freeze for three ticks, then release
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check_status("freeze");
    end
    check_square("frozen");
    tick(1'b0);
    check_status("release1");
    check_square("release1");
    tick(1'b0);
    check_status("release2");
    check_square("release2");

    // Long animate pulse with a single strobe: exactly one step
    i_animate = 1'b1; i_active = 1'b0; i_freeze = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_pix_stb = (i == 7);
      @(posedge i_clk); #1;
    end
    i_pix_stb = 1'b0; i_animate = 1'b0;
    model_tick(1'b0);
    check_status("long_anim");
    check_square("long_anim");

    // Randomised frames with occasional freeze requests
    for (int f = 0; f < 300; f++) begin
      tick($urandom_range(0, 4) == 0);
      if (f % 10 == 0) begin
        check_status("rnd");
        check_square("rnd");
      end
    end

    // Reset mid-frame, coinciding with a tick that must be ignored
    pix(mcx, mcy, 1'b1, "pre_rst");
    i_rst = 1'b1; i_pix_stb = 1'b1; i_animate = 1'b1; i_active = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_pix_stb = 1'b0; i_animate = 1'b0;
    model_reset();
    check("mrst_rgb", {20'd0, o_r, o_g, o_b}, 32'd0);
    check_status("mrst");
    pix(360, 260, 1'b1, "mrst_p360_260");
    pix(359, 300, 1'b1, "mrst_p359_300");
    check_square("mrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
